rf_wb_ctrl: RTL and testbench
=============================

// Module: rf_wb_ctrl
// PURPOSE
//  Write-side driver for the 32x32 integer register file; the single source of its wen/waddr/wdata port.
//  Merges EXU (ALU/CSR) results and LSU load responses into one registered write per cycle.
//  Sign-/zero-extends load data and suppresses writes to x0.
//  Exports a pending-rd mask so the IDU scoreboard can stall on queued destinations.
// PARAMETERS
//  ADDR_WIDTH      5   register index width
//  DATA_WIDTH      32  register data width
//  EXU_FIFO_DEPTH  2   EXU result queue depth; power of two, >=2
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  exu_valid   in   1   EXU result offered
//  exu_ready   out  1   EXU result accepted when valid&&ready
//  exu_rd      in   5   EXU destination register
//  exu_data    in   32  EXU result
//  lsu_valid   in   1   load response offered
//  lsu_ready   out  1   load response accepted when valid&&ready
//  lsu_rd      in   5   load destination register
//  lsu_rdata   in   32  raw aligned memory word
//  lsu_size    in   2   0=byte 1=half 2=word 3=illegal
//  lsu_uns     in   1   1=zero-extend, 0=sign-extend
//  lsu_addr_lo in   2   byte offset of the load address
//  rf_wen      out  1   register-file write enable
//  rf_waddr    out  5   register-file write address
//  rf_wdata    out  32  register-file write data
//  ld_misalign out  1   one-cycle pulse: load dropped (misaligned or size 3)
//  pend_mask   out  32  bit i set while any queued EXU entry targets xi
//  idle        out  1   FIFO empty and no write in flight
// BEHAVIOUR
//  - Reset: rf_wen=0, rf_waddr=0, rf_wdata=0, ld_misalign=0, FIFO emptied, pend_mask=0.
//    exu_ready=0 and lsu_ready=0 while rst=1. Reset mid-operation discards queued results.
//  - lsu_ready=1 whenever rst=0; a load is never back-pressured.
//  - exu_ready = !fifo_full, from registered count only; no combinational path from exu_valid or lsu_valid.
//  - Each accepted EXU beat is pushed into the FIFO. Push and pop in the same cycle keep the count unchanged.
//  - Arbitration each cycle, LSU first:
//    - lsu_valid=1: the load is the write source; the FIFO does not pop.
//    - else if the FIFO is non-empty: pop the head; it is the write source.
//    - else: no write (rf_wen=0 next cycle).
//  - Latency: the source selected in cycle N drives rf_wen/rf_waddr/rf_wdata in cycle N+1 (registered).
//    An EXU beat accepted into an empty FIFO with no load competing writes at the earliest 2 cycles later.
//  - x0: a selected source with rd==0 is consumed normally, but rf_wen=0 for that cycle.
//  - Load extension: lane = rdata >> (8*addr_lo). Byte: lane[7:0]; half: lane[15:0]; word: rdata.
//    Sign-extend unless lsu_uns=1.
//  - Misaligned load (half with addr_lo[0]=1, word with addr_lo!=0, or size 3):
//    the load is consumed, rf_wen=0, and ld_misalign=1 in cycle N+1.
//  - pend_mask: OR of the one-hot rd of every valid FIFO entry, recomputed from registered FIFO state.
//    Bit 0 is always 0.
//  - Ordering contract: the IDU does not issue a load whose rd has its pend_mask bit set.
//    Under that contract, LSU priority never reorders writes to the same rd.
//  - idle = FIFO empty && rf_wen==0.
// STRUCTURE
//  - Package rf_wb_pkg holds:
//    - LSU_SZ_B/H/W/ILL size encodings.
//    - Function load_ext(rdata,size,uns,addr_lo) returning {err,data}.
//  - Sub-module rf_wb_fifo: parameterised sync FIFO with {rd,data} payload.
//    Exposes count, full and empty, plus a per-entry valid/rd view used to build pend_mask.
//  - The top level contains the arbiter, extender instance and output registers.
// TESTING
//  - Reset with exu_valid=1: exu_ready=0, rf_wen=0 and pend_mask=0 throughout; the first push happens 1 cycle after rst falls.
//  - EXU rd=5 data=0x1234 with idle LSU: rf_wen=1, waddr=5, wdata=0x1234 exactly 2 cycles after the handshake.
//  - Load byte 0x000080FF: addr_lo=1 signed -> 0xFFFFFF80; addr_lo=1 unsigned -> 0x00000080; addr_lo=0 signed -> 0xFFFFFFFF.
//  - Half load with addr_lo=1, rd=7: rf_wen=0 and ld_misalign=1 for exactly one cycle; the following EXU write is unaffected.
//  - lsu_valid held for 3 cycles while EXU pushes rd=3 then rd=4:
//    - FIFO fills; exu_ready=0; pend_mask=0x18.
//    - Three load writes occur, then rd=3 then rd=4.
//  - EXU rd=0 data=0xDEAD: the beat is consumed, rf_wen stays 0 and idle returns to 1.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: load size encodings and the load extender shared by the register-file write path.
package rf_wb_pkg;
  localparam logic [1:0] LSU_SZ_B   = 2'd0;
  localparam logic [1:0] LSU_SZ_H   = 2'd1;
  localparam logic [1:0] LSU_SZ_W   = 2'd2;
  localparam logic [1:0] LSU_SZ_ILL = 2'd3;
  function automatic logic [32:0] load_ext(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic uns, input logic [1:0] addr_lo);
    logic [31:0] lane;
    logic err;
    lane = rdata >> {addr_lo, 3'b000};
    err  = (size == LSU_SZ_ILL) || (size == LSU_SZ_H && addr_lo[0]) || (size == LSU_SZ_W && addr_lo != 2'd0);
    return {err, size == LSU_SZ_B ? {{24{lane[7] & ~uns}}, lane[7:0]} :
                 size == LSU_SZ_H ? {{16{lane[15] & ~uns}}, lane[15:0]} : rdata};
  endfunction
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: sync {rd,data} FIFO exposing count/full/empty, head and a per-entry valid/rd view.
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_rd,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [AW-1:0]              head_rd,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_rd
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0][AW+DW-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {push_rd, push_data};
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign {head_rd, head_data} = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  // An entry is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off          = PW'(i) - rd_q;
    assign ent_valid[i] = {1'b0, off} < cnt_q;
    assign ent_rd[i]    = mem_q[i][AW+DW-1:DW];
  end
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: merges EXU results and LSU loads into one registered register-file write per cycle.
module rf_wb_ctrl import rf_wb_pkg::*; #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int EXU_FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_rdata,
  input  logic [1:0]               lsu_size,
  input  logic                     lsu_uns,
  input  logic [1:0]               lsu_addr_lo,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     ld_misalign,
  output logic [2**ADDR_WIDTH-1:0] pend_mask,
  output logic                     idle
);
  logic push, pop, fifo_full, fifo_empty;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [$clog2(EXU_FIFO_DEPTH):0] fifo_cnt;
  logic [EXU_FIFO_DEPTH-1:0] ent_valid;
  logic [EXU_FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ent_rd;
  logic [32:0] ext;
  logic rf_wen_q, rf_wen_d, mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  assign exu_ready = !rst && !fifo_full;
  assign lsu_ready = !rst;
  assign push      = exu_valid && exu_ready;
  assign pop       = !lsu_valid && !fifo_empty;
  rf_wb_fifo #(.DEPTH(EXU_FIFO_DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (exu_rd),
    .push_data (exu_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );
  assign ext = load_ext(32'(lsu_rdata), lsu_size, lsu_uns, lsu_addr_lo);
  always_comb begin
    rf_wen_d = lsu_valid ? !ext[32] && lsu_rd != '0 : pop && head_rd != '0;
    waddr_d  = lsu_valid ? lsu_rd : pop ? head_rd : waddr_q;
    wdata_d  = lsu_valid ? DATA_WIDTH'(ext[31:0]) : pop ? head_data : wdata_q;
    mis_d    = lsu_valid && ext[32];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      rf_wen_q <= rf_wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
    end
  end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < EXU_FIFO_DEPTH; i++) if (ent_valid[i]) pend_mask[ent_rd[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end
  assign rf_wen      = rf_wen_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign ld_misalign = mis_q;
  assign idle        = fifo_cnt == '0 && !rf_wen_q;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed vectors and multi-cycle sequences for rf_wb_ctrl.
module tb_rf_wb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic exu_valid = 1'b0, exu_ready;
  logic [4:0] exu_rd = '0;
  logic [31:0] exu_data = '0;
  logic lsu_valid = 1'b0, lsu_ready;
  logic [4:0] lsu_rd = '0;
  logic [31:0] lsu_rdata = '0;
  logic [1:0] lsu_size = '0, lsu_addr_lo = '0;
  logic lsu_uns = 1'b0;
  logic rf_wen, ld_misalign, idle;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, pend_mask;
  int errs = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    logic        mis;
  } ld_vec_t;
  ld_vec_t vecs[10];
  rf_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_size(lsu_size), .lsu_uns(lsu_uns), .lsu_addr_lo(lsu_addr_lo),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ld_misalign(ld_misalign), .pend_mask(pend_mask), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wr(input string name, input logic wen, input logic [4:0] a, input logic [31:0] d);
    chk({name, " wen"}, 32'(rf_wen), 32'(wen));
    if (wen) begin
      chk({name, " waddr"}, 32'(rf_waddr), 32'(a));
      chk({name, " wdata"}, rf_wdata, d);
    end
  endtask
  initial begin
    vecs[0] = '{32'h000080FF, 2'd0, 1'b0, 2'd1, 5'd10, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[1] = '{32'h000080FF, 2'd0, 1'b1, 2'd1, 5'd10, 1'b1, 32'h00000080, 1'b0};
    vecs[2] = '{32'h000080FF, 2'd0, 1'b0, 2'd0, 5'd11, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{32'h80010000, 2'd1, 1'b0, 2'd2, 5'd12, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[4] = '{32'h1234F00D, 2'd1, 1'b1, 2'd0, 5'd13, 1'b1, 32'h0000F00D, 1'b0};
    vecs[5] = '{32'hCAFEBABE, 2'd2, 1'b0, 2'd0, 5'd14, 1'b1, 32'hCAFEBABE, 1'b0};
    vecs[6] = '{32'hCAFEBABE, 2'd2, 1'b0, 2'd2, 5'd15, 1'b0, 32'h0, 1'b1};
    vecs[7] = '{32'h11111111, 2'd3, 1'b0, 2'd0, 5'd16, 1'b0, 32'h0, 1'b1};
    vecs[8] = '{32'h7F000000, 2'd0, 1'b0, 2'd3, 5'd0, 1'b0, 32'h0, 1'b0};
    vecs[9] = '{32'h85000000, 2'd0, 1'b0, 2'd3, 5'd31, 1'b1, 32'hFFFFFF85, 1'b0};
    exu_valid = 1'b1;
    exu_rd = 5'd9;
    exu_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst exu_ready", 32'(exu_ready), 0);
      chk("rst lsu_ready", 32'(lsu_ready), 0);
      chk("rst rf_wen", 32'(rf_wen), 0);
      chk("rst pend_mask", pend_mask, 0);
    end
    chk("rst waddr", 32'(rf_waddr), 0);
    chk("rst wdata", rf_wdata, 0);
    chk("rst misalign", 32'(ld_misalign), 0);
    rst = 1'b0;
    #1;
    chk("post-rst exu_ready", 32'(exu_ready), 1);
    chk("post-rst lsu_ready", 32'(lsu_ready), 1);
    tick();
    chk("first push pend", pend_mask, 32'h200);
    chk("first push wen", 32'(rf_wen), 0);
    exu_valid = 1'b0;
    tick();
    wr("first write", 1'b1, 5'd9, 32'h99);
    chk("first write pend", pend_mask, 0);
    tick();
    chk("after first wen", 32'(rf_wen), 0);
    chk("after first idle", 32'(idle), 1);
    exu_valid = 1'b1;
    exu_rd = 5'd5;
    exu_data = 32'h1234;
    tick();
    exu_valid = 1'b0;
    chk("exu5 +1 wen", 32'(rf_wen), 0);
    tick();
    wr("exu5 +2", 1'b1, 5'd5, 32'h1234);
    for (int i = 0; i < 10; i++) begin
      lsu_valid = 1'b1;
      lsu_rdata = vecs[i].rdata;
      lsu_size = vecs[i].size;
      lsu_uns = vecs[i].uns;
      lsu_addr_lo = vecs[i].lo;
      lsu_rd = vecs[i].rd;
      tick();
      wr($sformatf("ld%0d", i), vecs[i].wen, vecs[i].rd, vecs[i].wdata);
      chk($sformatf("ld%0d misalign", i), 32'(ld_misalign), 32'(vecs[i].mis));
    end
    lsu_valid = 1'b1;
    lsu_size = 2'd1;
    lsu_addr_lo = 2'd1;
    lsu_rd = 5'd7;
    exu_valid = 1'b1;
    exu_rd = 5'd12;
    exu_data = 32'h55;
    tick();
    lsu_valid = 1'b0;
    exu_valid = 1'b0;
    chk("mis pulse", 32'(ld_misalign), 1);
    chk("mis wen", 32'(rf_wen), 0);
    tick();
    chk("mis pulse end", 32'(ld_misalign), 0);
    wr("exu after mis", 1'b1, 5'd12, 32'h55);
    tick();
    lsu_valid = 1'b1;
    lsu_size = 2'd2;
    lsu_addr_lo = 2'd0;
    lsu_rd = 5'd20;
    lsu_rdata = 32'hA0;
    exu_valid = 1'b1;
    exu_rd = 5'd3;
    exu_data = 32'h33;
    tick();
    wr("fill ld20", 1'b1, 5'd20, 32'hA0);
    chk("fill ready1", 32'(exu_ready), 1);
    lsu_rd = 5'd21;
    lsu_rdata = 32'hA1;
    exu_rd = 5'd4;
    exu_data = 32'h44;
    tick();
    wr("fill ld21", 1'b1, 5'd21, 32'hA1);
    chk("fill full ready", 32'(exu_ready), 0);
    chk("fill pend", pend_mask, 32'h18);
    lsu_rd = 5'd22;
    lsu_rdata = 32'hA2;
    exu_rd = 5'd8;
    exu_data = 32'h88;
    tick();
    wr("fill ld22", 1'b1, 5'd22, 32'hA2);
    chk("fill still full", 32'(exu_ready), 0);
    chk("fill pend2", pend_mask, 32'h18);
    lsu_valid = 1'b0;
    exu_valid = 1'b0;
    tick();
    wr("drain rd3", 1'b1, 5'd3, 32'h33);
    chk("drain pend", pend_mask, 32'h10);
    chk("drain ready", 32'(exu_ready), 1);
    tick();
    wr("drain rd4", 1'b1, 5'd4, 32'h44);
    chk("drain pend0", pend_mask, 0);
    tick();
    chk("drain end wen", 32'(rf_wen), 0);
    chk("drain idle", 32'(idle), 1);
    exu_valid = 1'b1;
    exu_rd = 5'd0;
    exu_data = 32'hDEAD;
    tick();
    exu_valid = 1'b0;
    chk("x0 queued idle", 32'(idle), 0);
    chk("x0 pend", pend_mask, 0);
    tick();
    chk("x0 wen", 32'(rf_wen), 0);
    chk("x0 idle", 32'(idle), 1);
    exu_valid = 1'b1;
    exu_rd = 5'd6;
    exu_data = 32'h66;
    tick();
    exu_valid = 1'b0;
    chk("midrst pend before", pend_mask, 32'h40);
    rst = 1'b1;
    tick();
    chk("midrst pend", pend_mask, 0);
    chk("midrst wen", 32'(rf_wen), 0);
    chk("midrst idle", 32'(idle), 1);
    rst = 1'b0;
    tick();
    chk("midrst discard wen", 32'(rf_wen), 0);
    tick();
    chk("midrst discard wen2", 32'(rf_wen), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
